// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and preset height table for the pipe height generator
package pipe_pkg;

    localparam int CW = 10;
    localparam int PIPE_SCREEN_H = 480;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    localparam logic [CW-1:0] PRESET [8] = '{
        10'd50, 10'd100, 10'd150, 10'd110, 10'd80, 10'd130, 10'd70, 10'd120
    };

    // Table lookup with the wrap-around used by both reset fill and generation
    function automatic logic [CW-1:0] preset_at(input int i);
        return PRESET[i % 8];
    endfunction

endpackage

// File: rtl/pipe_lfsr16.sv
// rtl/pipe_lfsr16.sv - seeded 16-bit Galois LFSR with enable and synchronous load
module pipe_lfsr16
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        load,
    input  logic        en,
    output logic [15:0] q
);

    // An all-zero state would lock the register, so a zero seed falls back to the default
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? LFSR_DEFAULT_SEED : SEED;

    // Load the seed or advance one Galois step
    always_ff @(posedge clk) begin
        if (load) begin
            q <= SEED_EFF;
        end else if (en) begin
            q <= q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
        end
    end

endmodule

// File: rtl/pipe_height_gen.sv
// rtl/pipe_height_gen.sv - pipe edge generator; random heights compiled in with PIPE_HGEN_LFSR_EN
module pipe_height_gen
    import pipe_pkg::*;
#(
    parameter int          N         = 4,
    parameter int          SCREEN_H  = PIPE_SCREEN_H,
    parameter int          Y_MIN     = 40,
    parameter int          Y_MAX     = 250,
    parameter int          GAP_MAX   = 180,
    parameter int          GAP_MIN   = 100,
    parameter int          GAP_STEP  = 20,
    parameter int          LEVEL_LEN = 8,
    parameter logic [15:0] SEED      = LFSR_DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    input  logic            restart,
    input  logic            rand_mode,
    output logic [N*CW-1:0] y_top,
    output logic [N*CW-1:0] y_bot,
    output logic [CW-1:0]   gap_cur,
    output logic [3:0]      level,
    output logic            new_valid
);

    localparam int CNT_W = (LEVEL_LEN > 1) ? $clog2(LEVEL_LEN) : 1;

    logic [CW-1:0]    top_q [N];
    logic [CW-1:0]    bot_q [N];
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CW-1:0]    new_top;
    logic             use_rand;
    logic             unused_cfg;

`ifdef PIPE_HGEN_LFSR_EN
    localparam int            RANGE = Y_MAX - Y_MIN + 1;
    localparam int            RW    = $clog2(RANGE);
    localparam logic [CW-1:0] RMASK = CW'((1 << RW) - 1);

    logic [15:0]   lfsr_q;
    logic [CW-1:0] raw;
    logic [CW-1:0] rand_off;

    pipe_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .load (rst),
        .en   (1'b1),
        .q    (lfsr_q)
    );

    // Mask to the next power of two, then one conditional subtract folds into [0, RANGE)
    always_comb begin
        raw      = lfsr_q[CW-1:0] & RMASK;
        rand_off = (raw >= CW'(RANGE)) ? (raw - CW'(RANGE)) : raw;
    end

    assign use_rand   = rand_mode;
    assign unused_cfg = &{1'b0, lfsr_q[15:CW], SCREEN_H != 0};
`else
    assign use_rand   = 1'b0;
    assign unused_cfg = &{1'b0, rand_mode, SEED[0], SCREEN_H != 0, Y_MIN != 0, Y_MAX != 0};
`endif

    // Height for the pipe entering slot N-1
    always_comb begin
        new_top = PRESET[idx_q];
`ifdef PIPE_HGEN_LFSR_EN
        if (use_rand) begin
            new_top = CW'(Y_MIN) + rand_off;
        end
`endif
    end

    // Slot shift, table index, level/gap progression and the new-pipe strobe
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            for (int i = 0; i < N; i++) begin
                top_q[i] <= preset_at(i);
                bot_q[i] <= CW'(preset_at(i) + GAP_MAX);
            end
            idx_q     <= 3'(N % 8);
            cnt_q     <= '0;
            gap_cur   <= CW'(GAP_MAX);
            level     <= '0;
            new_valid <= 1'b0;
        end else begin
            new_valid <= advance;
            if (advance) begin
                for (int i = 0; i < N - 1; i++) begin
                    top_q[i] <= top_q[i+1];
                    bot_q[i] <= bot_q[i+1];
                end
                top_q[N-1] <= new_top;
                bot_q[N-1] <= new_top + gap_cur;
                if (!use_rand) begin
                    idx_q <= idx_q + 3'd1;
                end
                if (32'(cnt_q) == LEVEL_LEN - 1) begin
                    cnt_q <= '0;
                    if (gap_cur >= CW'(GAP_MIN + GAP_STEP)) begin
                        gap_cur <= gap_cur - CW'(GAP_STEP);
                    end else begin
                        gap_cur <= CW'(GAP_MIN);
                    end
                    if (level != 4'd15) begin
                        level <= level + 4'd1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // Flatten slot registers onto the packed output buses
    always_comb begin
        y_top = '0;
        y_bot = '0;
        for (int i = 0; i < N; i++) begin
            y_top[CW*i +: CW] = top_q[i];
            y_bot[CW*i +: CW] = bot_q[i];
        end
    end

endmodule
